oled_bus_sequencer: RTL

Controller that owns the SSD1306 OLED bus (reset, chip-select, clock, data, D/C) between system reset and CPU hand-off. After reset it pulses the panel reset, shifts a fixed 13-byte SSD1306 initialisation sequence over SPI mode 0, and then grants the bus to the ATmega32U4 core's SPI/GPIO pins. It sits between the core's OLED pins and the on-chip SSD1306 emulator or external panel. A re-init request replays the sequence without a system reset.

---
 rtl/oled_bus_sequencer.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/oled_bus_sequencer.sv
// Owns the SSD1306 OLED bus after reset: pulses panel reset, shifts the 13-byte init sequence (SPI mode 0), then hands the bus to the CPU.
// Latency: sequencer outputs are registered; in CPU mode the oled_* pins are combinational copies of cpu_* (zero cycles).
// Backpressure: none; hand-off waits for cpu_ss=1, and a reinit seen while cpu_ss=0 is held pending until cpu_ss=1.
module oled_bus_sequencer #(
  parameter int    CLK_DIV         = 2,
  parameter int    RST_LOW_CYCLES  = 160,
  parameter int    RST_WAIT_CYCLES = 1600,
  parameter string BYPASS          = "FALSE"
) (
  input  logic sys_clk,
  input  logic rst,
  input  logic cpu_ss,
  input  logic cpu_scl,
  input  logic cpu_mosi,
  input  logic cpu_dc,
  input  logic cpu_rst_n,
  input  logic reinit,
  output logic oled_ss,
  output logic oled_scl,
  output logic oled_mosi,
  output logic oled_dc,
  output logic oled_rst_n,
  output logic cpu_grant,
  output logic busy,
  output logic done
);

  localparam bit BYP     = (BYPASS == "TRUE");
  localparam int DLY_MAX = (RST_LOW_CYCLES > RST_WAIT_CYCLES) ? RST_LOW_CYCLES : RST_WAIT_CYCLES;
  localparam int DLY_W   = ($clog2(DLY_MAX + 1) > 11) ? $clog2(DLY_MAX + 1) : 11;

  localparam logic [DLY_W-1:0] LOW_END  = DLY_W'(RST_LOW_CYCLES - 1);
  localparam logic [DLY_W-1:0] WAIT_END = DLY_W'(RST_WAIT_CYCLES - 1);
  localparam logic [DLY_W-1:0] DIV_END  = DLY_W'(CLK_DIV - 1);
  localparam logic [3:0]       LAST_BYTE = 4'd12;

  typedef enum logic [2:0] {
    S_RST_LOW,
    S_RST_WAIT,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_HANDOFF,
    S_CPU
  } state_t;

  state_t           state;
  logic [DLY_W-1:0] dly_cnt;
  logic [2:0]       bit_cnt;
  logic [3:0]       byte_cnt;
  logic             pending;
  logic             seq_ss;
  logic             seq_scl;
  logic             seq_mosi;
  logic             seq_rst_n;
  logic [7:0]       cur_byte;
  logic [7:0]       nxt_byte;

  // SSD1306 init command stream, all sent with D/C low.
  function automatic logic [7:0] init_byte(input logic [3:0] idx);
    case (idx)
      4'd0:    init_byte = 8'hD5;
      4'd1:    init_byte = 8'hF0;
      4'd2:    init_byte = 8'h8D;
      4'd3:    init_byte = 8'h14;
      4'd4:    init_byte = 8'hA1;
      4'd5:    init_byte = 8'hC8;
      4'd6:    init_byte = 8'h81;
      4'd7:    init_byte = 8'hCF;
      4'd8:    init_byte = 8'hD9;
      4'd9:    init_byte = 8'hF1;
      4'd10:   init_byte = 8'hAF;
      4'd11:   init_byte = 8'h20;
      default: init_byte = 8'h00;
    endcase
  endfunction

  assign cur_byte = init_byte(byte_cnt);
  assign nxt_byte = init_byte(byte_cnt + 4'd1);

  // Bus ownership mux: CPU pins pass straight through once granted.
  assign oled_ss    = cpu_grant ? cpu_ss    : seq_ss;
  assign oled_scl   = cpu_grant ? cpu_scl   : seq_scl;
  assign oled_mosi  = cpu_grant ? cpu_mosi  : seq_mosi;
  assign oled_dc    = cpu_grant ? cpu_dc    : 1'b0;
  assign oled_rst_n = cpu_grant ? cpu_rst_n : seq_rst_n;

  // Sequencer FSM with registered bus outputs, grant/busy/done and reinit tracking.
  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state     <= BYP ? S_CPU : S_RST_LOW;
      dly_cnt   <= '0;
      bit_cnt   <= '0;
      byte_cnt  <= '0;
      pending   <= 1'b0;
      seq_ss    <= 1'b1;
      seq_scl   <= 1'b0;
      seq_mosi  <= 1'b0;
      seq_rst_n <= 1'b0;
      cpu_grant <= BYP;
      busy      <= !BYP;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_RST_LOW: begin
          if (dly_cnt == LOW_END) begin
            dly_cnt   <= '0;
            seq_rst_n <= 1'b1;
            state     <= S_RST_WAIT;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        S_RST_WAIT: begin
          if (dly_cnt == WAIT_END) begin
            dly_cnt <= '0;
            seq_ss  <= 1'b0;
            state   <= S_SETUP;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        S_SETUP: begin
          if (dly_cnt == DIV_END) begin
            dly_cnt  <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            seq_mosi <= init_byte(4'd0) >> 7;
            state    <= S_SHIFT;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (dly_cnt == DIV_END) begin
            dly_cnt <= '0;
            if (!seq_scl) begin
              seq_scl <= 1'b1;
            end else begin
              // Falling edge: present the next bit while scl is low.
              seq_scl <= 1'b0;
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                if (byte_cnt == LAST_BYTE) begin
                  byte_cnt <= '0;
                  seq_mosi <= 1'b0;
                  state    <= S_HOLD;
                end else begin
                  byte_cnt <= byte_cnt + 4'd1;
                  seq_mosi <= nxt_byte[7];
                end
              end else begin
                bit_cnt  <= bit_cnt + 3'd1;
                seq_mosi <= cur_byte[3'd6 - bit_cnt];
              end
            end
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        S_HOLD: begin
          if (dly_cnt == DIV_END) begin
            dly_cnt <= '0;
            seq_ss  <= 1'b1;
            state   <= S_HANDOFF;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        S_HANDOFF: begin
          // Never grant into the middle of a CPU transfer.
          if (cpu_ss) begin
            cpu_grant <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_CPU;
          end
        end
        default: begin
          if ((reinit || pending) && cpu_ss) begin
            pending   <= 1'b0;
            cpu_grant <= 1'b0;
            busy      <= 1'b1;
            dly_cnt   <= '0;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            seq_ss    <= 1'b1;
            seq_scl   <= 1'b0;
            seq_mosi  <= 1'b0;
            seq_rst_n <= 1'b0;
            state     <= S_RST_LOW;
          end else if (reinit) begin
            pending <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule
